// File: rtl/seq101_ctx_scheduler_pkg.sv
// Shared types and pure helpers for the time-multiplexed "101" detector.
package seq101_pkg;

    // Detector context: S1 idle, S2 seen "1", S3 seen "10", S4 seen "101".
    typedef enum logic [1:0] {
        S1 = 2'b00,
        S2 = 2'b01,
        S3 = 2'b10,
        S4 = 2'b11
    } seq_state_t;

    // Overlapping next-state rule; S4 behaves like S2 because its trailing "1" can start a new match.
    function automatic seq_state_t seq101_next(input seq_state_t s, input logic b);
        seq_state_t n;
        unique case (s)
            S1:      n = b ? S2 : S1;
            S2:      n = b ? S2 : S3;
            S3:      n = b ? S4 : S1;
            default: n = b ? S2 : S3;
        endcase
        return n;
    endfunction

    function automatic logic is_match(input seq_state_t s);
        return (s == S4);
    endfunction

endpackage

// File: rtl/seq101_ctx_scheduler_if.sv
// Lane-side and status-side signal bundle of the context scheduler.
interface seq101_ctx_scheduler_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    localparam int CH_W = $clog2(NCH);

    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_bit;
    logic [NCH-1:0]       in_ready;
    logic [NCH-1:0]       clr_ch;
    logic                 det_valid;
    logic [CH_W-1:0]      det_ch;
    logic                 det_match;
    logic [NCH*CNT_W-1:0] match_cnt;

    // Upstream / consumer view.
    modport master (
        output in_valid, in_bit, clr_ch,
        input  in_ready, det_valid, det_ch, det_match, match_cnt
    );

    // Scheduler view.
    modport slave (
        input  in_valid, in_bit, clr_ch,
        output in_ready, det_valid, det_ch, det_match, match_cnt
    );

endinterface

// File: rtl/seq101_ctx_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above the pointer, with wrap.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    logic [IW-1:0] ptr;
    int            idx;

    // Search upward from the pointer; only the first hit is granted, so grant is one-hot or zero.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && req[idx]) begin
                any_grant      = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end

    // Pointer moves just past the winner; idle cycles leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (any_grant) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/seq101_ctx_scheduler.sv
// One shared "101" Moore engine serving NCH lanes, with saved per-lane context and match counters.
module seq101_ctx_scheduler
    import seq101_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    seq101_ctx_scheduler_if.slave  bus
);

    localparam int CH_W = $clog2(NCH);

    seq_state_t       ctx [NCH];
    logic [CNT_W-1:0] cnt [NCH];

    logic [NCH-1:0]   req;
    logic [NCH-1:0]   grant;
    logic [CH_W-1:0]  grant_idx;
    logic             any_grant;
    seq_state_t       nxt_g;

    logic             vld_p1;
    logic             match_p1;
    logic [CH_W-1:0]  ch_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A lane being cleared is not eligible, so a clear and a consume never hit the same context.
    assign req = bus.in_valid & ~bus.clr_ch;

    rr_arbiter #(.N(NCH), .IW(CH_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign bus.in_ready = grant;
    assign nxt_g        = seq101_next(ctx[grant_idx], bus.in_bit[grant_idx]);

    // ---- stage p0 -> p1: context write-back and counter update ----
    // Only the granted lane advances; cleared lanes return to idle; all others stay frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                ctx[i] <= S1;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.clr_ch[i]) begin
                    ctx[i] <= S1;
                    cnt[i] <= '0;
                end else if (grant[i]) begin
                    ctx[i] <= nxt_g;
                    if (is_match(nxt_g)) begin
                        cnt[i] <= sat_inc(cnt[i]);
                    end
                end
            end
        end
    end

    // Report the lane processed this cycle; det_match reflects the written-back state only.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            match_p1 <= 1'b0;
            ch_p1    <= '0;
        end else if (any_grant) begin
            vld_p1   <= 1'b1;
            match_p1 <= is_match(nxt_g);
            ch_p1    <= grant_idx;
        end else begin
            vld_p1   <= 1'b0;
            match_p1 <= 1'b0;
        end
    end

    assign bus.det_valid = vld_p1;
    assign bus.det_match = match_p1;
    assign bus.det_ch    = ch_p1;

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign bus.match_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

endmodule

// File: tb/tb_seq101_ctx_scheduler.sv
// Self-checking bench for seq101_ctx_scheduler with a history-based reference model.
module tb_seq101_ctx_scheduler;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seq101_ctx_scheduler_if #(.NCH(NCH), .CNT_W(8)) bus ();
    seq101_ctx_scheduler_if #(.NCH(NCH), .CNT_W(2)) bus2 ();

    seq101_ctx_scheduler #(.NCH(NCH), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq101_ctx_scheduler #(.NCH(NCH), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: last three bits seen since clear, bit count, match count, rr pointer.
    logic [2:0] m_hist [NCH];
    int         m_len  [NCH];
    int         m_cnt  [NCH];
    int         m_rr;
    logic       exp_vld, exp_match;
    logic [1:0] exp_ch;

    logic       obs_vld, obs_match;
    logic [1:0] obs_ch;
    logic [3:0] obs_ready;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_hist[i] = 3'b000;
            m_len[i]  = 0;
            m_cnt[i]  = 0;
        end
        m_rr      = 0;
        exp_vld   = 1'b0;
        exp_match = 1'b0;
        exp_ch    = 2'd0;
    endtask

    // Drive one cycle, check in_ready and the registered results against the model.
    task automatic run_cycle(input logic [3:0] v, input logic [3:0] b,
                             input logic [3:0] c, input logic r);
        int          g;
        int          idx;
        logic        mt;
        logic [3:0]  exp_ready;
        logic [31:0] exp_cnt;
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.clr_ch   = c;
        rst          = r;
        #1;
        g = -1;
        for (int k = 0; k < NCH; k++) begin
            idx = (m_rr + k) % NCH;
            if (g < 0 && v[idx] && !c[idx]) g = idx;
        end
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
        obs_ready = bus.in_ready;
        n_checks++;
        if (bus.in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready: got %b expected %b", bus.in_ready, exp_ready);
        end
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (c[i]) begin
                    m_hist[i] = 3'b000;
                    m_len[i]  = 0;
                    m_cnt[i]  = 0;
                end
            end
            if (g >= 0) begin
                m_hist[g] = {m_hist[g][1:0], b[g]};
                m_len[g]++;
                mt = (m_len[g] >= 3) && (m_hist[g] == 3'b101);
                if (mt && m_cnt[g] < 255) m_cnt[g]++;
                m_rr      = (g + 1) % NCH;
                exp_vld   = 1'b1;
                exp_ch    = 2'(g);
                exp_match = mt;
            end else begin
                exp_vld   = 1'b0;
                exp_match = 1'b0;
            end
        end
        for (int i = 0; i < NCH; i++) exp_cnt[i*8 +: 8] = 8'(m_cnt[i]);
        @(posedge clk);
        #1;
        obs_vld   = bus.det_valid;
        obs_match = bus.det_match;
        obs_ch    = bus.det_ch;
        n_checks++;
        if (bus.det_valid !== exp_vld) begin
            n_fail++;
            $display("FAIL det_valid: got %b expected %b", bus.det_valid, exp_vld);
        end
        n_checks++;
        if (bus.det_match !== exp_match) begin
            n_fail++;
            $display("FAIL det_match: got %b expected %b", bus.det_match, exp_match);
        end
        n_checks++;
        if (bus.det_ch !== exp_ch) begin
            n_fail++;
            $display("FAIL det_ch: got %0d expected %0d", bus.det_ch, exp_ch);
        end
        n_checks++;
        if (bus.match_cnt !== exp_cnt) begin
            n_fail++;
            $display("FAIL match_cnt: got %h expected %h", bus.match_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = '0;
        bus.in_bit    = '0;
        bus.clr_ch    = '0;
        bus2.in_valid = '0;
        bus2.in_bit   = '0;
        bus2.clr_ch   = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.det_valid !== 1'b0 || bus.det_match !== 1'b0 || bus.det_ch !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_det: got v=%b m=%b ch=%0d expected 0 0 0",
                     bus.det_valid, bus.det_match, bus.det_ch);
        end
        n_checks++;
        if (bus.match_cnt !== 32'h0 || bus2.match_cnt !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h/%h expected 0", bus.match_cnt, bus2.match_cnt);
        end
        n_checks++;
        if (bus.in_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready_idle: got %b expected 0000", bus.in_ready);
        end
        model_reset();
        run_cycle(4'hF, 4'h0, 4'h0, 1'b1);
    endtask

    task automatic test_lane0_pattern();
        logic [4:0] pat;
        logic       want;
        pat = 5'b10101;
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            run_cycle(4'b0001, {3'b000, pat[j]}, 4'h0, 1'b0);
            want = (j == 2 || j == 4);
            n_checks++;
            if (obs_ready[0] !== 1'b1 || obs_match !== want) begin
                n_fail++;
                $display("FAIL lane0_bit%0d: got ready=%b match=%b expected 1 %b",
                         j, obs_ready[0], obs_match, want);
            end
        end
        n_checks++;
        if (bus.match_cnt[7:0] !== 8'd2) begin
            n_fail++;
            $display("FAIL lane0_count: got %0d expected 2", bus.match_cnt[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] b;
        logic       want;
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        for (int j = 0; j < 12; j++) begin
            b = ((j / 4) == 1) ? 4'b0000 : 4'b1010;
            run_cycle(4'hF, b, 4'h0, 1'b0);
            want = (j == 9 || j == 11);
            n_checks++;
            if (obs_ch !== 2'(j % 4) || obs_match !== want) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: got ch=%0d match=%b expected ch=%0d match=%b",
                         j, obs_ch, obs_match, j % 4, want);
            end
        end
        n_checks++;
        if (bus.match_cnt[15:8] !== 8'd1 || bus.match_cnt[31:24] !== 8'd1) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d %0d expected 1 1",
                     bus.match_cnt[15:8], bus.match_cnt[31:24]);
        end
    endtask

    task automatic test_clear();
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        run_cycle(4'b0100, 4'b0100, 4'h0, 1'b0);
        run_cycle(4'b0100, 4'b0000, 4'h0, 1'b0);
        run_cycle(4'b0100, 4'b0100, 4'h0, 1'b0);
        run_cycle(4'b0100, 4'b0000, 4'h0, 1'b0);
        run_cycle(4'b0100, 4'b0100, 4'b0100, 1'b0);
        n_checks++;
        if (obs_ready[2] !== 1'b0 || obs_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_cycle: got ready=%b vld=%b expected 0 0", obs_ready[2], obs_vld);
        end
        run_cycle(4'b0100, 4'b0100, 4'h0, 1'b0);
        n_checks++;
        if (obs_match !== 1'b0 || bus.match_cnt[23:16] !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_after: got match=%b cnt=%0d expected 0 0",
                     obs_match, bus.match_cnt[23:16]);
        end
        run_cycle(4'b0100, 4'b0000, 4'h0, 1'b0);
        run_cycle(4'b0100, 4'b0100, 4'h0, 1'b0);
        n_checks++;
        if (obs_match !== 1'b1 || bus.match_cnt[23:16] !== 8'd1) begin
            n_fail++;
            $display("FAIL clear_ctx_s2: got match=%b cnt=%0d expected 1 1",
                     obs_match, bus.match_cnt[23:16]);
        end
    endtask

    task automatic test_saturation();
        int   hist_len;
        int   want_cnt;
        logic want;
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        want_cnt = 0;
        hist_len = 0;
        for (int j = 0; j < 9; j++) begin
            bus2.in_valid = 4'b0001;
            bus2.in_bit   = {3'b000, (j % 2 == 0)};
            run_cycle(4'h0, 4'h0, 4'h0, 1'b0);
            hist_len++;
            want = (hist_len >= 3) && (j % 2 == 0);
            if (want && want_cnt < 3) want_cnt++;
            n_checks++;
            if (bus2.det_match !== want || bus2.match_cnt[1:0] !== 2'(want_cnt)) begin
                n_fail++;
                $display("FAIL sat_bit%0d: got match=%b cnt=%0d expected %b %0d",
                         j, bus2.det_match, bus2.match_cnt[1:0], want, want_cnt);
            end
        end
        bus2.in_valid = 4'b0000;
        bus2.in_bit   = 4'b0000;
    endtask

    task automatic test_rst_mid();
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        run_cycle(4'b0010, 4'b0010, 4'h0, 1'b0);
        run_cycle(4'b0010, 4'b0000, 4'h0, 1'b0);
        run_cycle(4'b0010, 4'b0010, 4'h0, 1'b1);
        n_checks++;
        if (obs_vld !== 1'b0 || obs_ready[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_cycle: got vld=%b ready=%b expected 0 1", obs_vld, obs_ready[1]);
        end
        run_cycle(4'b0010, 4'b0010, 4'h0, 1'b0);
        n_checks++;
        if (obs_match !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_nomatch: got %b expected 0", obs_match);
        end
        run_cycle(4'b0010, 4'b0000, 4'h0, 1'b0);
        run_cycle(4'b0010, 4'b0010, 4'h0, 1'b0);
        n_checks++;
        if (obs_match !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ctx_s2: got %b expected 1", obs_match);
        end
    endtask

    task automatic test_skip_idle();
        logic [3:0] want;
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        run_cycle(4'b0001, 4'h0, 4'h0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            want = (j % 2 == 0) ? 4'b0100 : 4'b0001;
            run_cycle(4'b0101, 4'h0, 4'h0, 1'b0);
            n_checks++;
            if (obs_ready !== want) begin
                n_fail++;
                $display("FAIL skip_grant%0d: got %b expected %b", j, obs_ready, want);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] v, b, c;
        logic       r;
        run_cycle(4'h0, 4'h0, 4'h0, 1'b1);
        for (int j = 0; j < 400; j++) begin
            v = 4'($urandom);
            b = 4'($urandom);
            c = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            r = ($urandom_range(0, 63) == 0);
            run_cycle(v, b, c, r);
        end
    endtask

    initial begin
        test_reset();
        test_lane0_pattern();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_rst_mid();
        test_skip_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
